// File: rtl/core_fetch_ctrl.sv
// Instruction-fetch control: owns the PC, keeps a single imem request in flight,
// presents fetched instructions to decode and redirects on taken branches/jumps.
module core_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_brnch_taken,
    input  logic        ex_jump,
    input  logic [31:0] ex_target,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        flush,
    output logic        misalign
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pend;
    logic        redirect;
    logic [31:0] target;

    assign redirect = ex_valid & (ex_brnch_taken | ex_jump);
    assign target   = {ex_target[31:2], 2'b00};

    // imem_addr doubles as the PC: it always names the next (or in-flight) fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pend      <= 32'h0000_0000;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_instr  <= NOP_INSTR;
            if_pc     <= RESET_PC;
            flush     <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            flush    <= redirect;
            misalign <= redirect & (ex_target[1:0] != 2'b00);
            case (state)
                FETCH: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            if (redirect) begin
                                imem_addr <= target;
                                if_valid  <= 1'b0;
                                if_instr  <= NOP_INSTR;
                            end else if (id_stall && if_valid) begin
                                // Decode still owns the held slot: drop this data and
                                // refetch the same PC once the stall clears.
                                imem_req <= 1'b0;
                                state    <= HOLD;
                            end else begin
                                if_valid  <= 1'b1;
                                if_instr  <= imem_rdata;
                                if_pc     <= imem_addr;
                                imem_addr <= imem_addr + 32'd4;
                                if (id_stall) begin
                                    imem_req <= 1'b0;
                                    state    <= HOLD;
                                end
                            end
                        end else if (redirect) begin
                            pend     <= target;
                            state    <= DROP;
                            if_valid <= 1'b0;
                            if_instr <= NOP_INSTR;
                        end else if (!id_stall) begin
                            if_valid <= 1'b0;
                            if_instr <= NOP_INSTR;
                        end
                    end else begin
                        imem_req <= 1'b1;
                        if (redirect) begin
                            imem_addr <= target;
                            if_valid  <= 1'b0;
                            if_instr  <= NOP_INSTR;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        imem_addr <= target;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                        if_valid  <= 1'b0;
                        if_instr  <= NOP_INSTR;
                    end else if (!id_stall) begin
                        imem_req <= 1'b1;
                        state    <= FETCH;
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                    end
                end
                DROP: begin
                    // Wrong-path request still in flight; the latest redirect wins.
                    if (imem_ack) begin
                        imem_addr <= redirect ? target : pend;
                        state     <= FETCH;
                    end else if (redirect) begin
                        pend <= target;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
